// File: rtl/vec_addsub_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | vec_addsub_if : handshake + operand/result bundle for vec_addsub_seq  |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
interface vec_addsub_if #(
  parameter int W  = 6,
  parameter int WC = 32
);
  logic            in_valid;
  logic            in_ready;
  logic            mode;
  logic [W*WC-1:0] L;
  logic [W*WC-1:0] E;
  logic            out_valid;
  logic            out_ready;
  logic [W*WC-1:0] result;
  logic [WC-1:0]   ovf;

  modport master (
    output in_valid, mode, L, E, out_ready,
    input  in_ready, out_valid, result, ovf
  );

  modport slave (
    input  in_valid, mode, L, E, out_ready,
    output in_ready, out_valid, result, ovf
  );
endinterface
`default_nettype wire

// File: rtl/vec_addsub_seq.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | vec_addsub_seq : time-multiplexed signed lane add/sub, P lanes/beat   |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module vec_addsub_seq #(
  parameter int W   = 6,
  parameter int WC  = 32,
  parameter int P   = 8,
  parameter bit SAT = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  vec_addsub_if.slave bus
);
  localparam int NB = WC / P;
  localparam int CW = (NB > 1) ? $clog2(NB) : 1;
  localparam int BW = P * W;
  localparam logic [CW-1:0] LAST_BEAT = CW'(NB - 1);

  generate
    if (WC % P != 0) begin : g_bad_p
      $error("vec_addsub_seq: WC must be a multiple of P");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [W*WC-1:0]  l_q, l_d;
  logic [W*WC-1:0]  e_q, e_d;
  logic             mode_q, mode_d;
  logic [W*WC-1:0]  result_q, result_d;
  logic [WC-1:0]    ovf_q, ovf_d;

  logic [BW-1:0]    beat_res;
  logic [P-1:0]     beat_ovf;

  // Operands shift down one beat per cycle, so the lane adders always
  // read the bottom P lanes of the captured copy.
  generate
    for (genvar j = 0; j < P; j++) begin : g_lane
      logic signed [W:0] a_x;
      logic signed [W:0] b_x;
      logic signed [W:0] sum;
      logic              lane_ovf;

      assign a_x      = {l_q[j*W+W-1], l_q[j*W +: W]};
      assign b_x      = {e_q[j*W+W-1], e_q[j*W +: W]};
      assign sum      = mode_q ? (a_x + b_x) : (a_x - b_x);
      assign lane_ovf = sum[W] ^ sum[W-1];

      assign beat_ovf[j]        = lane_ovf;
      assign beat_res[j*W +: W] = (lane_ovf && SAT) ? {sum[W], {(W-1){~sum[W]}}}
                                                    : sum[W-1:0];
    end
  endgenerate

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    l_d      = l_q;
    e_d      = e_q;
    mode_d   = mode_q;
    result_d = result_q;
    ovf_d    = ovf_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          l_d      = bus.L;
          e_d      = bus.E;
          mode_d   = bus.mode;
          cnt_d    = '0;
          result_d = '0;
          ovf_d    = '0;
          state_d  = RUN;
        end
      end
      RUN: begin
        result_d[int'(cnt_q)*BW +: BW] = beat_res;
        ovf_d[int'(cnt_q)*P +: P]      = beat_ovf;
        l_d = l_q >> BW;
        e_d = e_q >> BW;
        if (cnt_q == LAST_BEAT) begin
          cnt_d   = '0;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      l_q      <= '0;
      e_q      <= '0;
      mode_q   <= 1'b0;
      result_q <= '0;
      ovf_q    <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      l_q      <= l_d;
      e_q      <= e_d;
      mode_q   <= mode_d;
      result_q <= result_d;
      ovf_q    <= ovf_d;
    end
  end

  // in_ready is gated by reset so the unit never advertises space while held.
  assign bus.in_ready  = rst && (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.result    = result_q;
  assign bus.ovf       = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_vec_addsub_seq.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_vec_addsub_seq : random + directed bench with a lane-level model  |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module tb_vec_addsub_seq;
  localparam int W  = 6;
  localparam int WC = 32;
  localparam int N  = W * WC;
  localparam int P0 = 8;
  localparam int P1 = 32;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  vec_addsub_if #(.W(W), .WC(WC)) bus0 ();
  vec_addsub_if #(.W(W), .WC(WC)) bus1 ();

  vec_addsub_seq #(.W(W), .WC(WC), .P(P0), .SAT(1'b1)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
  vec_addsub_seq #(.W(W), .WC(WC), .P(P1), .SAT(1'b0)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Lane-wise reference: plain integer arithmetic, then range test.
  task automatic model(input logic [N-1:0] l, input logic [N-1:0] e, input logic m,
                       input bit sat, output logic [N-1:0] r, output logic [WC-1:0] o);
    int a, b, s;
    for (int k = 0; k < WC; k++) begin
      a = $signed(l[k*W +: W]);
      b = $signed(e[k*W +: W]);
      s = m ? a + b : a - b;
      o[k] = (s > 31) || (s < -32);
      if (sat && s > 31)       s = 31;
      else if (sat && s < -32) s = -32;
      r[k*W +: W] = W'(s);
    end
  endtask

  // Transaction-level model: 0 idle, 1 computing (mage beats done), 2 holding result.
  int               mst [2];
  int               mage[2];
  logic [N-1:0]     er  [2];
  logic [WC-1:0]    eo  [2];

  task automatic step(input int u, input logic iv, input logic [N-1:0] l, input logic [N-1:0] e,
                      input logic m, input logic ordy);
    case (mst[u])
      0: if (iv) begin
           model(l, e, m, (u == 0), er[u], eo[u]);
           mst[u]  = 1;
           mage[u] = 0;
         end
      1: begin
           mage[u]++;
           if (mage[u] == ((u == 0) ? WC / P0 : WC / P1)) mst[u] = 2;
         end
      default: if (ordy) mst[u] = 0;
    endcase
  endtask

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      mst[0] = 0; mst[1] = 0; mage[0] = 0; mage[1] = 0;
    end else begin
      step(0, bus0.in_valid, bus0.L, bus0.E, bus0.mode, bus0.out_ready);
      step(1, bus1.in_valid, bus1.L, bus1.E, bus1.mode, bus1.out_ready);
    end
  end

  task automatic chk(input int u, input logic ir, input logic ov,
                     input logic [N-1:0] res, input logic [WC-1:0] of);
    logic [N-1:0]  xr;
    logic [WC-1:0] xo;
    int            p;
    p = (u == 0) ? P0 : P1;
    if (!rst) begin
      check($sformatf("u%0d reset in_ready", u), N'(ir), '0);
      check($sformatf("u%0d reset out_valid", u), N'(ov), '0);
      check($sformatf("u%0d reset result", u), res, '0);
      check($sformatf("u%0d reset ovf", u), N'(of), '0);
    end else begin
      check($sformatf("u%0d in_ready", u), N'(ir), N'(mst[u] == 0));
      check($sformatf("u%0d out_valid", u), N'(ov), N'(mst[u] == 2));
      if (mst[u] != 0) begin
        xr = '0;
        xo = '0;
        for (int k = 0; k < WC; k++) begin
          if (mst[u] == 2 || k < mage[u] * p) begin
            xr[k*W +: W] = er[u][k*W +: W];
            xo[k]        = eo[u][k];
          end
        end
        check($sformatf("u%0d result", u), res, xr);
        check($sformatf("u%0d ovf", u), N'(of), N'(xo));
      end
    end
  endtask

  always @(negedge clk) begin
    chk(0, bus0.in_ready, bus0.out_valid, bus0.result, bus0.ovf);
    chk(1, bus1.in_ready, bus1.out_valid, bus1.result, bus1.ovf);
  end

  function automatic logic [N-1:0] rand_vec();
    logic [N-1:0] v;
    for (int i = 0; i < N / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  function automatic logic get_ir(input int u);  return (u == 0) ? bus0.in_ready  : bus1.in_ready;  endfunction
  function automatic logic get_ov(input int u);  return (u == 0) ? bus0.out_valid : bus1.out_valid; endfunction
  function automatic logic [N-1:0]  get_res(input int u); return (u == 0) ? bus0.result : bus1.result; endfunction
  function automatic logic [WC-1:0] get_ovf(input int u); return (u == 0) ? bus0.ovf : bus1.ovf; endfunction

  task automatic drive(input int u, input logic iv, input logic [N-1:0] l, input logic [N-1:0] e,
                       input logic m);
    if (u == 0) begin
      bus0.in_valid = iv; bus0.L = l; bus0.E = e; bus0.mode = m;
    end else begin
      bus1.in_valid = iv; bus1.L = l; bus1.E = e; bus1.mode = m;
    end
  endtask

  task automatic set_ordy(input int u, input logic v);
    if (u == 0) bus0.out_ready = v;
    else        bus1.out_ready = v;
  endtask

  task automatic do_vec(input int u, input logic [N-1:0] l, input logic [N-1:0] e, input logic m,
                        input int hold, output logic [N-1:0] r, output logic [WC-1:0] o,
                        output int lat);
    int n;
    n = 0;
    @(negedge clk);
    while (!get_ir(u) && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      checks++; errors++;
      $display("FAIL u%0d accept timeout: in_ready stayed low", u);
    end
    drive(u, 1'b1, l, e, m);
    @(posedge clk); #1;
    drive(u, 1'b0, rand_vec(), rand_vec(), 1'($urandom));
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!get_ov(u) && n < 50);
    lat = n;
    if (!get_ov(u)) begin
      checks++; errors++;
      $display("FAIL u%0d completion timeout: out_valid=0 required 1", u);
    end
    r = get_res(u);
    o = get_ovf(u);
    repeat (hold) begin
      @(posedge clk); #1;
      drive(u, 1'b0, rand_vec(), rand_vec(), 1'($urandom));
      check($sformatf("u%0d held result", u), get_res(u), r);
      check($sformatf("u%0d held in_ready", u), N'(get_ir(u)), '0);
    end
    set_ordy(u, 1'b1);
    @(posedge clk); #1;
    set_ordy(u, 1'b0);
    check($sformatf("u%0d out_valid after handshake", u), N'(get_ov(u)), '0);
    check($sformatf("u%0d in_ready after handshake", u), N'(get_ir(u)), N'(1'b1));
  endtask

  logic [N-1:0]  l, e, r;
  logic [WC-1:0] o;
  int            lat;

  initial begin
    drive(0, 1'b0, '0, '0, 1'b0);
    drive(1, 1'b0, '0, '0, 1'b0);
    set_ordy(0, 1'b0);
    set_ordy(1, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    check("reset result", bus0.result, '0);
    check("reset in_ready", N'(bus0.in_ready), '0);
    @(negedge clk) rst = 1'b1;

    // Subtract, all lanes 5-3
    do_vec(0, {WC{6'd5}}, {WC{6'd3}}, 1'b0, 0, r, o, lat);
    check("sub basic result", r, {WC{6'd2}});
    check("sub basic ovf", N'(o), '0);
    check("sub basic latency", N'(lat), N'(4));

    // Add saturate both directions
    l = '0; e = '0;
    l[0 +: W] = 6'd31;       e[0 +: W] = 6'd1;
    l[W +: W] = 6'b100000;   e[W +: W] = 6'b111111;
    do_vec(0, l, e, 1'b1, 0, r, o, lat);
    check("add sat lane0", N'(r[0 +: W]), N'(6'd31));
    check("add sat lane1", N'(r[W +: W]), N'(6'b100000));
    check("add sat ovf", N'(o), N'(32'h3));

    // Subtract saturate both directions
    l = '0; e = '0;
    l[0 +: W] = 6'b100000;   e[0 +: W] = 6'd1;
    l[W +: W] = 6'd31;       e[W +: W] = 6'b100000;
    do_vec(0, l, e, 1'b0, 0, r, o, lat);
    check("sub sat lane0", N'(r[0 +: W]), N'(6'b100000));
    check("sub sat lane1", N'(r[W +: W]), N'(6'd31));
    check("sub sat ovf", N'(o), N'(32'h3));

    // Wrapping, single-beat unit
    l = '0; e = '0;
    l[0 +: W] = 6'd31;       e[0 +: W] = 6'd1;
    do_vec(1, l, e, 1'b1, 0, r, o, lat);
    check("wrap lane0", N'(r[0 +: W]), N'(6'b100000));
    check("wrap ovf", N'(o), N'(32'h1));
    check("wrap latency", N'(lat), N'(1));

    // Backpressure with churning inputs
    do_vec(0, rand_vec(), rand_vec(), 1'b1, 10, r, o, lat);

    // Reset after the second beat
    @(negedge clk);
    drive(0, 1'b1, rand_vec(), rand_vec(), 1'b0);
    @(posedge clk); #1;
    drive(0, 1'b0, '0, '0, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    check("midrun reset out_valid", N'(bus0.out_valid), '0);
    check("midrun reset result", bus0.result, '0);
    check("midrun reset ovf", N'(bus0.ovf), '0);
    check("midrun reset in_ready", N'(bus0.in_ready), '0);
    @(posedge clk);
    @(negedge clk) rst = 1'b1;
    do_vec(0, {WC{6'd5}}, {WC{6'd3}}, 1'b0, 0, r, o, lat);
    check("after reset result", r, {WC{6'd2}});

    for (int i = 0; i < 40; i++) begin
      do_vec($urandom_range(0, 1), rand_vec(), rand_vec(), 1'($urandom),
             $urandom_range(0, 3), r, o, lat);
    end

    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
`default_nettype wire
